mtm_alu_tx_scheduler: RTL and testbench

Output-side controller for the ALU's frame serializer. It queues result responses and error responses from the ALU core, arbitrates between them, and sequences the serializer one response at a time with a start/busy handshake. It also enforces a configurable idle gap between responses. It sits between the ALU core/decoder and the serializer that drives `sout`.

---
 rtl/mtm_alu_tx_scheduler.sv | 158 +++++++++++++++
 tb/tb_mtm_alu_tx_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_tx_scheduler.sv
// Output-side scheduler: queues ALU result/error responses and sequences the frame serializer.
// Build option MTM_ALU_TX_ERR_PRIO_EN: a pending error always beats queued results (no round-robin).
module mtm_alu_tx_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        res_valid,
  output logic                        res_ready,
  input  logic [31:0]                 res_C,
  input  logic [7:0]                  res_CTL,
  input  logic                        err_valid,
  output logic                        err_ready,
  input  logic [7:0]                  err_CTL,
  output logic                        ser_start,
  output logic [31:0]                 ser_C,
  output logic [7:0]                  ser_CTL,
  input  logic                        ser_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        tx_fault
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (GAP_CYCLES > 4) ? GAP_CYCLES : 4;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(3);
  localparam logic [CNT_W-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_SEND, S_GAP} state_t;

  function automatic logic is_legal_err(input logic [7:0] ctl);
    return (ctl == 8'hC9) || (ctl == 8'h93) || (ctl == 8'hA5);
  endfunction

  state_t           state, state_nxt;
  logic [31:0]      fifo_c   [FIFO_DEPTH];
  logic [7:0]       fifo_ctl [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   level;
  logic             err_full;
  logic [7:0]       err_ctl_q;
  logic             sel_err;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr, cnt_inc, fault_set, launch_go;
  logic             push, err_load, res_pend, grant_err, pop_res, pop_err;

  assign push       = res_valid && res_ready;
  assign err_load   = err_valid && err_ready && is_legal_err(err_CTL);
  assign res_pend   = (level != '0);
  assign pop_res    = (state == S_LAUNCH) && !sel_err;
  assign pop_err    = (state == S_LAUNCH) && sel_err;
  assign res_ready  = (level != LEVEL_FULL);
  assign err_ready  = !err_full;
  assign ser_start  = (state == S_LAUNCH);
  assign fifo_level = level;

`ifdef MTM_ALU_TX_ERR_PRIO_EN
  assign grant_err = err_full;
`else
  // last_err starts as "error" so a result wins the first tie after reset
  logic last_err;
  assign grant_err = err_full && (!res_pend || !last_err);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_err <= 1'b1;
    end else if (launch_go) begin
      last_err <= grant_err;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    launch_go = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    fault_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (res_pend || err_full) begin
          launch_go = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_clr   = 1'b1;
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (ser_busy) begin
          state_nxt = S_SEND;
        end else if (cnt == TMO_LAST) begin
          fault_set = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_SEND: begin
        if (!ser_busy) begin
          cnt_clr   = 1'b1;
          state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      err_full <= 1'b0;
      sel_err  <= 1'b0;
      cnt      <= '0;
      tx_fault <= 1'b0;
      ser_C    <= '0;
      ser_CTL  <= '0;
    end else begin
      state <= state_nxt;
      if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_res) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop_res)      level <= level + (PTR_W + 1)'(1);
      else if (!push && pop_res) level <= level - (PTR_W + 1)'(1);
      if (err_load)     err_full <= 1'b1;
      else if (pop_err) err_full <= 1'b0;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (fault_set) tx_fault <= 1'b1;
      // Output word is captured once per response and held through the whole transmission
      if (launch_go) begin
        sel_err <= grant_err;
        ser_C   <= grant_err ? 32'h0 : fifo_c[rd_ptr];
        ser_CTL <= grant_err ? err_ctl_q : fifo_ctl[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_c[wr_ptr]   <= res_C;
      fifo_ctl[wr_ptr] <= res_CTL;
    end
    if (err_load) err_ctl_q <= err_CTL;
  end

endmodule

// File: tb/tb_mtm_alu_tx_scheduler.sv
// Bench for mtm_alu_tx_scheduler: directed scenarios plus random traffic against a queue-based
// reference model of the response ordering, with a behavioural serializer driving ser_busy.
`timescale 1ns/1ps
module tb_mtm_alu_tx_scheduler;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;
`ifdef MTM_ALU_TX_ERR_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     res_valid = 1'b0;
  logic                     res_ready;
  logic [31:0]              res_C = '0;
  logic [7:0]               res_CTL = '0;
  logic                     err_valid = 1'b0;
  logic                     err_ready;
  logic [7:0]               err_CTL = '0;
  logic                     ser_start;
  logic [31:0]              ser_C;
  logic [7:0]               ser_CTL;
  logic                     ser_busy = 1'b0;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     tx_fault;

  always #5 clk = ~clk;

  mtm_alu_tx_scheduler #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_C(res_C), .res_CTL(res_CTL),
    .err_valid(err_valid), .err_ready(err_ready), .err_CTL(err_CTL),
    .ser_start(ser_start), .ser_C(ser_C), .ser_CTL(ser_CTL), .ser_busy(ser_busy),
    .fifo_level(fifo_level), .tx_fault(tx_fault)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state
  logic [39:0] mq[$];
  bit          merr_full = 0;
  logic [7:0]  merr_ctl  = '0;
  bit          last_err  = 1;
  bit          snap_res = 0, snap_err = 0;
  logic [31:0] prev_C = '0;
  logic [7:0]  prev_CTL = '0;
  int          n_starts = 0, last_start = 0, last_fall = 0;
  // serializer model
  bit          ser_never = 0, prev_busy = 0;
  int          ser_dly = 1, ser_len = 3, busy_from = 0, busy_to = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit legal_err(input logic [7:0] c);
    return c inside {8'hC9, 8'h93, 8'hA5};
  endfunction

  // One clock: book this cycle's handshakes, advance, then check outputs and drive ser_busy.
  task automatic step();
    bit cur_res, cur_err, win_err;
    logic [39:0] exp_frame;
    if (rst_n) begin
      if (res_valid && res_ready) mq.push_back({res_C, res_CTL});
      if (err_valid && err_ready && legal_err(err_CTL)) begin
        merr_full = 1;
        merr_ctl  = err_CTL;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      mq.delete();
      merr_full = 0; last_err = 1; snap_res = 0; snap_err = 0;
      prev_C = '0; prev_CTL = '0;
      busy_from = 0; busy_to = 0; ser_busy = 0; prev_busy = 0;
      last_start = 0; last_fall = 0;
      return;
    end
    chk("fifo_level", fifo_level, mq.size());
    chk("res_ready", res_ready, mq.size() != DEPTH);
    chk("err_ready", err_ready, !merr_full);
    cur_res = (mq.size() > 0);
    cur_err = merr_full;
    if (ser_start) begin
      n_starts++;
      chk("start_pending", snap_res || snap_err, 1'b1);
      if (snap_res || snap_err) begin
        if (PRIO)                     win_err = snap_err;
        else if (snap_res && snap_err) win_err = !last_err;
        else                          win_err = snap_err;
        exp_frame = win_err ? {32'h0, merr_ctl} : mq[0];
        chk("frame", {ser_C, ser_CTL}, exp_frame);
        if (win_err) merr_full = 0;
        else void'(mq.pop_front());
        last_err = win_err;
      end
      if (last_fall > last_start) chk("gap_min", (cyc - last_fall) >= GAP + 2, 1'b1);
      last_start = cyc;
      if (ser_never) begin
        busy_from = 0;
        busy_to   = 0;
      end else begin
        busy_from = cyc + ser_dly;
        busy_to   = busy_from + ser_len;
      end
    end else begin
      chk("ser_hold", {ser_C, ser_CTL}, {prev_C, prev_CTL});
    end
    prev_C = ser_C;
    prev_CTL = ser_CTL;
    snap_res = cur_res;
    snap_err = cur_err;
    ser_busy = (cyc >= busy_from) && (cyc < busy_to);
    if (prev_busy && !ser_busy) last_fall = cyc;
    prev_busy = ser_busy;
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && n_starts < target; i++) step();
    chk({tag, "_start_seen"}, n_starts >= target, 1'b1);
  endtask

  task automatic push_res(input logic [31:0] c, input logic [7:0] ctl, input int budget);
    bit done;
    done = 0;
    res_valid = 1; res_C = c; res_CTL = ctl;
    for (int i = 0; i < budget && !done; i++) begin
      done = res_ready;
      step();
    end
    res_valid = 0;
    chk("push_accept", done, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ser_start"}, ser_start, 1'b0);
    chk({tag, "_ser_C"}, ser_C, 32'h0);
    chk({tag, "_ser_CTL"}, ser_CTL, 8'h0);
    chk({tag, "_tx_fault"}, tx_fault, 1'b0);
    chk({tag, "_fifo_level"}, fifo_level, 0);
    chk({tag, "_res_ready"}, res_ready, 1'b1);
    chk({tag, "_err_ready"}, err_ready, 1'b1);
  endtask

  task automatic reset_dut(input string tag);
    rst_n = 0; res_valid = 0; err_valid = 0; ser_never = 0;
    step();
    step();
    check_reset_vals(tag);
    rst_n = 1;
    step();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = (mq.size() == 0) && !merr_full && !ser_busy && (cyc >= busy_to + GAP + 2);
    end
    chk({tag, "_drained"}, ok, 1'b1);
  endtask

  initial begin
    int t, n, s, l;
    reset_dut("rst0");

    // single result: latency and inter-frame gap
    ser_dly = 1; ser_len = 5;
    t = n_starts; n = cyc;
    push_res(32'hDEADBEEF, 8'h2A, 2);
    wait_starts("single", t + 1, 10);
    chk("single_latency", last_start, n + 2);
    chk("single_C", ser_C, 32'hDEADBEEF);
    chk("single_CTL", ser_CTL, 8'h2A);
    s = last_start;
    step();
    push_res(32'hCAFEF00D, 8'h11, 2);
    wait_starts("second", t + 2, 30);
    chk("busy_fall", last_fall, s + 6);
    chk("gap_exact", last_start, last_fall + GAP + 2);
    wait_drain("single", 50);

    // queue full while the serializer is busy for a long frame
    reset_dut("rst_qf");
    ser_dly = 1; ser_len = 55;
    t = n_starts;
    push_res(32'h1000_0000, 8'h10, 5);
    wait_starts("qf_first", t + 1, 10);
    step();
    step();
    for (int k = 1; k <= 4; k++) push_res(32'h1000_0000 + k, 8'h10 + k, 5);
    chk("qf_level", fifo_level, 4);
    chk("qf_ready_low", res_ready, 1'b0);
    push_res(32'h1000_0005, 8'h15, 100);
    wait_drain("qf", 500);

    // tie between a result and an error right after reset
    reset_dut("rst_tie");
    ser_dly = 1; ser_len = 3;
    t = n_starts;
    res_valid = 1; res_C = 32'h12345678; res_CTL = 8'h05;
    err_valid = 1; err_CTL = 8'h93;
    step();
    res_valid = 0; err_valid = 0;
    wait_starts("tie1", t + 1, 10);
    chk("tie1_CTL", ser_CTL, PRIO ? 8'h93 : 8'h05);
    wait_starts("tie2", t + 2, 30);
    chk("tie2_CTL", ser_CTL, PRIO ? 8'h05 : 8'h93);
    chk("tie2_C", ser_C, PRIO ? 32'h12345678 : 32'h0);
    wait_drain("tie", 50);

    // serializer never acknowledges
    reset_dut("rst_tmo");
    ser_never = 1;
    t = n_starts;
    push_res(32'hA0A0A0A0, 8'h01, 2);
    push_res(32'hB0B0B0B0, 8'h02, 2);
    wait_starts("tmo1", t + 1, 10);
    l = last_start;
    for (int i = 0; i < 10 && cyc < l + 4; i++) step();
    chk("tmo_fault_pre", tx_fault, 1'b0);
    step();
    chk("tmo_fault_set", tx_fault, 1'b1);
    wait_starts("tmo2", t + 2, 10);
    chk("tmo_relaunch", last_start, l + 6);
    for (int i = 0; i < 8; i++) step();
    chk("tmo_fault_sticky", tx_fault, 1'b1);

    // reset while a frame is being sent with entries queued
    reset_dut("rst_mid");
    ser_dly = 1; ser_len = 40;
    for (int k = 0; k < 4; k++) push_res(32'h5000_0000 + k, 8'h20 + k, 2);
    step();
    step();
    step();
    chk("mid_level", fifo_level, 3);
    rst_n = 0;
    step();
    check_reset_vals("mid");
    rst_n = 1;
    s = n_starts;
    for (int i = 0; i < 8; i++) step();
    chk("mid_no_start", n_starts, s);

    // illegal error code is accepted and dropped
    reset_dut("rst_ill");
    chk("ill_ready_before", err_ready, 1'b1);
    err_valid = 1; err_CTL = 8'hFF;
    step();
    err_valid = 0;
    chk("ill_ready_after", err_ready, 1'b1);
    s = n_starts;
    for (int i = 0; i < 12; i++) step();
    chk("ill_no_start", n_starts, s);

    // random traffic
    reset_dut("rst_rand");
    for (int i = 0; i < 1500; i++) begin
      res_valid = ($urandom_range(0, 2) == 0);
      res_C     = $urandom;
      res_CTL   = 8'($urandom_range(0, 127));
      err_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 4))
        0: err_CTL = 8'hC9;
        1: err_CTL = 8'h93;
        2: err_CTL = 8'hA5;
        3: err_CTL = 8'hFF;
        default: err_CTL = 8'($urandom);
      endcase
      ser_dly = $urandom_range(1, 3);
      ser_len = $urandom_range(1, 8);
      step();
    end
    res_valid = 0; err_valid = 0;
    wait_drain("rand", 2000);
    chk("rand_no_fault", tx_fault, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
